// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared constants, opcode encodings, FSM states and helpers for branch resolution.
package branch_resolve_ctrl_pkg;

  localparam int PC_W     = 16;
  localparam int NUM_WAYS = 4;

  localparam logic [3:0] OP_JUMP   = 4'b0110;
  localparam logic [3:0] OP_JUMPL  = 4'b0111;
  localparam logic [3:0] OP_JUMPG  = 4'b1000;
  localparam logic [3:0] OP_JUMPE  = 4'b1001;
  localparam logic [3:0] OP_JUMPNE = 4'b1010;

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FLUSH  = 1'b1
  } brc_state_e;

  // True for any of the five branch opcodes.
  function automatic logic is_jump(input logic [3:0] op);
    logic r;
    case (op)
      OP_JUMP, OP_JUMPL, OP_JUMPG, OP_JUMPE, OP_JUMPNE: r = 1'b1;
      default:                                          r = 1'b0;
    endcase
    return r;
  endfunction

  // Actual branch direction from opcode and condition flags.
  function automatic logic jump_taken(input logic [3:0] op, input logic lf,
                                      input logic gf, input logic zf);
    logic r;
    case (op)
      OP_JUMP:   r = 1'b1;
      OP_JUMPL:  r = lf;
      OP_JUMPG:  r = gf;
      OP_JUMPE:  r = zf;
      OP_JUMPNE: r = ~zf;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) r = v;
    else               r = v + 16'd1;
    return r;
  endfunction

endpackage

// File: rtl/branch_resolve_ctrl_plru4.sv
// 4-way tree pseudo-LRU: bit0 picks the half, bit1/bit2 pick within the left/right pair.
module plru4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       touch_en,
  input  logic [3:0] touch_way,
  output logic [3:0] victim
);

  logic [2:0] tree_q;
  logic [2:0] tree_d;

  // Point the tree away from the touched way so it becomes most-recently-used.
  always_comb begin
    tree_d = tree_q;
    if (touch_en) begin
      case (touch_way)
        4'b0001: begin tree_d[0] = 1'b1; tree_d[1] = 1'b1; end
        4'b0010: begin tree_d[0] = 1'b1; tree_d[1] = 1'b0; end
        4'b0100: begin tree_d[0] = 1'b0; tree_d[2] = 1'b1; end
        4'b1000: begin tree_d[0] = 1'b0; tree_d[2] = 1'b0; end
        default: tree_d = tree_q;
      endcase
    end else begin
      tree_d = tree_q;
    end
  end

  // Tree state register; reset selects way 0 as first victim.
  always_ff @(posedge clk) begin
    if (rst) tree_q <= 3'b000;
    else     tree_q <= tree_d;
  end

  // Follow the tree bits down to the least-recently-used leaf.
  always_comb begin
    victim = 4'b0001;
    if (!tree_q[0]) begin
      if (tree_q[1]) victim = 4'b0010;
      else           victim = 4'b0001;
    end else begin
      if (tree_q[2]) victim = 4'b1000;
      else           victim = 4'b0100;
    end
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Tracks fetched instructions to EX, detects branch mispredicts, issues
// flush/redirect and BTB updates, and counts mispredicts.
module branch_resolve_ctrl #(
  parameter int PC_W     = branch_resolve_ctrl_pkg::PC_W,
  parameter int NUM_WAYS = branch_resolve_ctrl_pkg::NUM_WAYS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                fetch_valid,
  input  logic [PC_W-1:0]     fetch_pc,
  input  logic                pred_taken,
  input  logic [PC_W-1:0]     pred_target,
  input  logic [NUM_WAYS-1:0] pred_hit_way,
  input  logic [3:0]          ex_opcode,
  input  logic                lflag,
  input  logic                gflag,
  input  logic                zflag,
  input  logic [PC_W-1:0]     ex_target,
  output logic                flush,
  output logic [PC_W-1:0]     redirect_pc,
  output logic                upd_en,
  output logic [NUM_WAYS-1:0] upd_way,
  output logic [PC_W-1:0]     upd_pc,
  output logic [PC_W-1:0]     upd_target,
  output logic                upd_taken,
  output logic [15:0]         mispredict_cnt
);
  import branch_resolve_ctrl_pkg::*;

  typedef struct packed {
    logic                valid;
    logic [PC_W-1:0]     pc;
    logic                pred_taken;
    logic [PC_W-1:0]     pred_target;
    logic [NUM_WAYS-1:0] hit_way;
  } stage_t;

  stage_t d_q, d_d, e_q, e_d;
  brc_state_e state_q, state_d;

  logic                flush_s;
  logic                jump_s, taken_s, resolve_s, mispredict_s;
  logic [3:0]          victim_s;

  logic [PC_W-1:0]     redirect_q, redirect_d;
  logic                upd_en_q, upd_en_d;
  logic [NUM_WAYS-1:0] upd_way_q, upd_way_d;
  logic [PC_W-1:0]     upd_pc_q, upd_pc_d;
  logic [PC_W-1:0]     upd_target_q, upd_target_d;
  logic                upd_taken_q, upd_taken_d;
  logic [15:0]         cnt_q, cnt_d;

  // Classify EX and decide mispredict; wrong-path E is never resolved during FLUSH.
  always_comb begin
    jump_s       = is_jump(ex_opcode);
    taken_s      = jump_taken(ex_opcode, lflag, gflag, zflag);
    resolve_s    = e_q.valid && !stall && (state_q == ST_NORMAL);
    mispredict_s = 1'b0;
    if (resolve_s) begin
      if (jump_s) begin
        mispredict_s = (taken_s != e_q.pred_taken) ||
                       (taken_s && (e_q.pred_target != ex_target));
      end else begin
        mispredict_s = e_q.pred_taken;
      end
    end else begin
      mispredict_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_NORMAL;
    else     state_q <= state_d;
  end

  // FSM next state: a mispredict buys exactly one FLUSH cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (mispredict_s) state_d = ST_FLUSH;
        else              state_d = ST_NORMAL;
      end
      ST_FLUSH: state_d = ST_NORMAL;
      default:  state_d = ST_NORMAL;
    endcase
  end

  // FSM output: flush pulse is the FLUSH state itself.
  always_comb begin
    flush_s = 1'b0;
    case (state_q)
      ST_FLUSH:  flush_s = 1'b1;
      ST_NORMAL: flush_s = 1'b0;
      default:   flush_s = 1'b0;
    endcase
  end

  // D/E tracking: flush clears valids even under stall, otherwise advance when not stalled.
  always_comb begin
    d_d = d_q;
    e_d = e_q;
    if (flush_s) begin
      d_d.valid       = 1'b0;
      d_d.pc          = fetch_pc;
      d_d.pred_taken  = pred_taken;
      d_d.pred_target = pred_target;
      d_d.hit_way     = pred_hit_way;
      e_d.valid       = 1'b0;
    end else if (!stall) begin
      d_d.valid       = fetch_valid;
      d_d.pc          = fetch_pc;
      d_d.pred_taken  = pred_taken;
      d_d.pred_target = pred_target;
      d_d.hit_way     = pred_hit_way;
      e_d             = d_q;
    end else begin
      d_d = d_q;
      e_d = e_q;
    end
  end

  // Redirect, BTB update and counter next values; data holds when idle.
  always_comb begin
    redirect_d   = redirect_q;
    upd_pc_d     = upd_pc_q;
    upd_target_d = upd_target_q;
    upd_taken_d  = upd_taken_q;
    upd_way_d    = upd_way_q;
    upd_en_d     = resolve_s && (jump_s || (e_q.hit_way != {NUM_WAYS{1'b0}}));
    if (mispredict_s) begin
      if (taken_s) redirect_d = ex_target;
      else         redirect_d = e_q.pc + {{(PC_W-1){1'b0}}, 1'b1};
    end else begin
      redirect_d = redirect_q;
    end
    if (upd_en_d) begin
      upd_pc_d     = e_q.pc;
      upd_target_d = ex_target;
      upd_taken_d  = jump_s ? taken_s : 1'b0;
      if (e_q.hit_way != {NUM_WAYS{1'b0}}) upd_way_d = e_q.hit_way;
      else                                 upd_way_d = victim_s;
    end else begin
      upd_way_d = upd_way_q;
    end
    if (flush_s) cnt_d = sat_inc16(cnt_q);
    else         cnt_d = cnt_q;
  end

  // Pipeline tracking and result registers; reset wins over stall and pending pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q          <= '0;
      e_q          <= '0;
      redirect_q   <= {PC_W{1'b0}};
      upd_en_q     <= 1'b0;
      upd_way_q    <= {NUM_WAYS{1'b0}};
      upd_pc_q     <= {PC_W{1'b0}};
      upd_target_q <= {PC_W{1'b0}};
      upd_taken_q  <= 1'b0;
      cnt_q        <= 16'h0000;
    end else begin
      d_q          <= d_d;
      e_q          <= e_d;
      redirect_q   <= redirect_d;
      upd_en_q     <= upd_en_d;
      upd_way_q    <= upd_way_d;
      upd_pc_q     <= upd_pc_d;
      upd_target_q <= upd_target_d;
      upd_taken_q  <= upd_taken_d;
      cnt_q        <= cnt_d;
    end
  end

  // Touch the way as the update is issued so back-to-back resolutions see fresh LRU.
  plru4 u_plru (
    .clk       (clk),
    .rst       (rst),
    .touch_en  (upd_en_d),
    .touch_way (upd_way_d),
    .victim    (victim_s)
  );

  assign flush          = flush_s;
  assign redirect_pc    = redirect_q;
  assign upd_en         = upd_en_q;
  assign upd_way        = upd_way_q;
  assign upd_pc         = upd_pc_q;
  assign upd_target     = upd_target_q;
  assign upd_taken      = upd_taken_q;
  assign mispredict_cnt = cnt_q;

endmodule

// File: doc/branch_resolve_ctrl.md
BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 16: PC and target width.
REQ-002 SHALL have parameter NUM_WAYS, default 4: BTB ways; upd_way and hit-way width.
REQ-003 SHALL have port clk, input, 1: single clock; all state on posedge clk.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port stall, input, 1: pipeline hold; tracking stages do not advance.
REQ-006 SHALL have port fetch_valid, input, 1: a fetch is issued this cycle.
REQ-007 SHALL have port fetch_pc, input, PC_W: PC of the fetched instruction.
REQ-008 SHALL have ports pred_taken (input, 1), pred_target (input, PC_W) and pred_hit_way (input, NUM_WAYS, one-hot, 0 = miss): BTB lookup result for fetch_pc.
REQ-009 SHALL have ports ex_opcode (input, 4), lflag, gflag, zflag (input, 1 each) and ex_target (input, PC_W): EX-stage opcode, flags and computed branch target.
REQ-010 SHALL have ports flush (output, 1) and redirect_pc (output, PC_W): squash pulse and correct fetch PC.
REQ-011 SHALL have ports upd_en (output, 1), upd_way (output, NUM_WAYS, one-hot), upd_pc (output, PC_W), upd_target (output, PC_W) and upd_taken (output, 1): BTB write command.
REQ-012 SHALL have port mispredict_cnt, output, 16: saturating mispredict count.

Function
REQ-013 SHALL track each fetch through regs D then E, each holding {valid, pc, pred_taken, pred_target, hit_way}; both advance only when stall=0.
REQ-014 SHALL classify jump_ins = ex_opcode in {0110 JUMP, 0111 JUMPL, 1000 JUMPG, 1001 JUMPE, 1010 JUMPNE}.
REQ-015 SHALL compute taken = 1 for JUMP, lflag for JUMPL, gflag for JUMPG, zflag for JUMPE, ~zflag for JUMPNE, else 0.
REQ-016 SHALL resolve E only when E.valid=1 and stall=0.
REQ-017 SHALL declare a mispredict when: jump_ins and taken != E.pred_taken; or jump_ins and taken and E.pred_target != ex_target; or !jump_ins and E.pred_taken (false hit).
REQ-018 SHALL, one cycle after a mispredict, pulse flush for exactly one cycle with redirect_pc = ex_target if taken, else E.pc+1 (mod 2^PC_W).
REQ-019 SHALL, in the cycle flush is asserted, clear D.valid and E.valid and capture the concurrent fetch as invalid (FSM NORMAL -> FLUSH -> NORMAL).
REQ-020 SHALL make flush override stall: valid bits clear even if stall=1.
REQ-021 SHALL, one cycle after resolving any jump_ins, pulse upd_en with upd_pc=E.pc, upd_target=ex_target and upd_taken=taken.
REQ-022 SHALL set upd_way = E.hit_way when nonzero; otherwise upd_way = the 4-way tree pseudo-LRU victim.
REQ-023 SHALL update PLRU on every upd_en so the written way becomes most-recently-used.
REQ-024 SHALL increment mispredict_cnt on each flush and saturate at 16'hFFFF.
REQ-025 SHALL send a false-hit update (upd_taken=0, upd_way=E.hit_way) for !jump_ins with nonzero E.hit_way.
REQ-026 SHALL hold redirect_pc and the upd_* data at their last values when flush=0 and upd_en=0.

Reset
REQ-027 SHALL, with rst=1 at posedge, clear all valid bits, PLRU bits (victim = way 0), mispredict_cnt, flush, upd_en, upd_way, redirect_pc, upd_pc, upd_target and upd_taken to 0, and set FSM to NORMAL.
REQ-028 SHALL make reset override stall and any pending flush or update; no pulse may follow reset.

Structure
REQ-029 SHALL place opcode constants, PC_W, NUM_WAYS and FSM state encodings in a shared package, reused by the BTB.
REQ-030 SHALL implement replacement as sub-module plru4 (3-bit tree, inputs touch_en/touch_way, output victim).

Verification
REQ-031 SHALL cover: JUMP at pc=0x0010, BTB miss, ex_target=0x0040 -> flush, redirect_pc=0x0040, upd_en, upd_way=0001, cnt=1.
REQ-032 SHALL cover: JUMPE hit way 0100 predicted taken to 0x0040, zflag=0 -> redirect_pc=0x0011, upd_taken=0, upd_way=0100.
REQ-033 SHALL cover: correctly predicted JUMPG, gflag=1, targets equal -> no flush, upd_en=1.
REQ-034 SHALL cover: four consecutive misses -> victims 0001, 0100, 0010, 1000.
REQ-035 SHALL cover: stall=1 with E resolvable, then mispredict during stall -> no resolution while stalled; a flush already pending still clears D/E.
REQ-036 SHALL cover: rst asserted the cycle after a mispredict -> no flush, cnt=0; and 65536 mispredicts -> cnt holds 0xFFFF.
